// File: rtl/uart.sv
// Full-duplex 8N(even)1 UART: transmitter and receiver share a bit-period
// setting that each side latches at frame start.
module uart (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RX,
    input  logic        START,
    input  logic [7:0]  DATA_TX,
    input  logic [11:0] WORK_FR,
    output logic        TX,
    output logic [7:0]  DATA_RX,
    output logic        PARITY_RX,
    output logic        READY_TX,
    output logic        READY
);

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_e;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_e;

    // Periods below 4 leave no room for a mid-bit sample behind the synchronizer.
    logic [11:0] period_d;
    assign period_d = (WORK_FR < 12'd4) ? 12'd4 : WORK_FR;

    // ---------------- transmitter ----------------
    tx_state_e   tx_state_q;
    logic [11:0] tx_per_q, tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        tx_par_q, tx_q, ready_tx_q;
    logic        tx_last;

    assign tx_last = (tx_cnt_q == tx_per_q - 12'd1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_state_q <= T_IDLE;
            tx_per_q   <= 12'd4;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            ready_tx_q <= 1'b1;
        end else begin
            if (tx_state_q != T_IDLE)
                tx_cnt_q <= tx_last ? 12'd0 : tx_cnt_q + 12'd1;
            case (tx_state_q)
                T_IDLE: if (START) begin
                    tx_shift_q <= DATA_TX;
                    tx_par_q   <= ^DATA_TX;
                    tx_per_q   <= period_d;
                    tx_cnt_q   <= '0;
                    tx_q       <= 1'b0;
                    ready_tx_q <= 1'b0;
                    tx_state_q <= T_START;
                end
                T_START: if (tx_last) begin
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                    tx_bit_q   <= '0;
                    tx_state_q <= T_DATA;
                end
                T_DATA: if (tx_last) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_q       <= tx_par_q;
                        tx_state_q <= T_PARITY;
                    end else begin
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_bit_q   <= tx_bit_q + 3'd1;
                    end
                end
                T_PARITY: if (tx_last) begin
                    tx_q       <= 1'b1;
                    tx_state_q <= T_STOP;
                end
                T_STOP: if (tx_last) begin
                    ready_tx_q <= 1'b1;
                    tx_state_q <= T_IDLE;
                end
                default: tx_state_q <= T_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    rx_state_e   rx_state_q;
    logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic [11:0] rx_per_q, rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q, data_rx_q;
    logic        rx_par_q, parity_rx_q, ready_q;
    logic        rx_last, rx_half;

    assign rx_last = (rx_cnt_q == rx_per_q - 12'd1);
    assign rx_half = (rx_cnt_q == (rx_per_q >> 1) - 12'd1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_sync1_q  <= 1'b1;
            rx_sync2_q  <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= R_IDLE;
            rx_per_q    <= 12'd4;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_par_q    <= 1'b0;
            data_rx_q   <= '0;
            parity_rx_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            rx_sync1_q <= RX;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            ready_q    <= 1'b0;
            if (rx_state_q != R_IDLE)
                rx_cnt_q <= rx_last ? 12'd0 : rx_cnt_q + 12'd1;
            case (rx_state_q)
                // Edge detect needs a high-then-low pair, so a line stuck low never retriggers.
                R_IDLE: if (rx_prev_q && !rx_sync2_q) begin
                    rx_per_q   <= period_d;
                    rx_cnt_q   <= '0;
                    rx_state_q <= R_START;
                end
                R_START: if (rx_half) begin
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rx_sync2_q ? R_IDLE : R_DATA;
                end
                R_DATA: if (rx_last) begin
                    rx_shift_q <= {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_q <= R_PARITY;
                    else                  rx_bit_q   <= rx_bit_q + 3'd1;
                end
                R_PARITY: if (rx_last) begin
                    rx_par_q   <= rx_sync2_q;
                    rx_state_q <= R_STOP;
                end
                R_STOP: if (rx_last) begin
                    if (rx_sync2_q) begin
                        data_rx_q   <= rx_shift_q;
                        parity_rx_q <= rx_par_q;
                        ready_q     <= 1'b1;
                    end
                    rx_state_q <= R_IDLE;
                end
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end

    assign TX        = tx_q;
    assign READY_TX  = ready_tx_q;
    assign DATA_RX   = data_rx_q;
    assign PARITY_RX = parity_rx_q;
    assign READY     = ready_q;

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: TX waveform, RX delivery/rejection, loopback, busy and reset.
module tb_uart;

    logic        CLK = 1'b0;
    logic        RESET, START, rx_drv, loop;
    logic [7:0]  DATA_TX;
    logic [11:0] WORK_FR;
    logic        TX, PARITY_RX, READY_TX, READY, RX;
    logic [7:0]  DATA_RX;

    int tests = 0;
    int fails = 0;
    int rdy_cnt = 0;
    logic [7:0] cap_d [8];
    logic       cap_p [8];

    assign RX = loop ? TX : rx_drv;

    uart dut (
        .CLK(CLK), .RESET(RESET), .RX(RX), .START(START), .DATA_TX(DATA_TX),
        .WORK_FR(WORK_FR), .TX(TX), .DATA_RX(DATA_RX), .PARITY_RX(PARITY_RX),
        .READY_TX(READY_TX), .READY(READY)
    );

    always #5 CLK = ~CLK;

    // Counts every cycle READY is high, so a stretched pulse shows up as an extra count.
    always @(negedge CLK) begin
        if (READY === 1'b1) begin
            if (rdy_cnt < 8) begin
                cap_d[rdy_cnt] <= DATA_RX;
                cap_p[rdy_cnt] <= PARITY_RX;
            end
            rdy_cnt <= rdy_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; START = 1'b0; DATA_TX = 8'h00; WORK_FR = 12'd16;
        rx_drv = 1'b1; loop = 1'b0;
        tick(2);
        RESET = 1'b0;
        tests++;
        if ({TX, READY_TX, READY, PARITY_RX} !== 4'b1100 || DATA_RX !== 8'h00) begin
            fails++;
            $display("FAIL reset: TX=%b RDY_TX=%b READY=%b PAR=%b DATA=%h, want 1 1 0 0 00",
                     TX, READY_TX, READY, PARITY_RX, DATA_RX);
        end
        tick(3);
    endtask

    task automatic test_tx_frame();
        logic [10:0] exp = {1'b1, 1'b0, 8'hA5, 1'b0};
        int bad = 0;
        WORK_FR = 12'd16; DATA_TX = 8'hA5; START = 1'b1;
        tick(1);
        START = 1'b0;
        for (int k = 0; k < 176; k++) begin
            if (TX !== exp[k/16] || READY_TX !== 1'b0) begin
                if (bad == 0)
                    $display("FAIL tx_frame cycle %0d: TX=%b RDY_TX=%b, want %b 0",
                             k, TX, READY_TX, exp[k/16]);
                bad++;
            end
            tick(1);
        end
        tests++;
        if (bad != 0) fails++;
        tests++;
        if (READY_TX !== 1'b1 || TX !== 1'b1) begin
            fails++;
            $display("FAIL tx_end: RDY_TX=%b TX=%b, want 1 1", READY_TX, TX);
        end
        tick(4);
    endtask

    task automatic test_min_period();
        int low = 0;
        WORK_FR = 12'd2; DATA_TX = 8'h3C; START = 1'b1;
        tick(1);
        START = 1'b0;
        while (READY_TX !== 1'b1 && low < 200) begin
            low++;
            tick(1);
        end
        tests++;
        if (low != 44) begin
            fails++;
            $display("FAIL min_period: busy %0d cycles, want 44", low);
        end
        tick(4);
    endtask

    task automatic test_rx_frame();
        logic [10:0] v = {1'b1, 1'b0, 8'h3C, 1'b0};
        int base = rdy_cnt;
        WORK_FR = 12'd16;
        for (int i = 0; i < 11; i++) begin
            rx_drv = v[i];
            tick(16);
        end
        rx_drv = 1'b1;
        tick(20);
        tests++;
        if (rdy_cnt - base != 1) begin
            fails++;
            $display("FAIL rx_ready_count: %0d, want 1", rdy_cnt - base);
        end
        tests++;
        if (DATA_RX !== 8'h3C || PARITY_RX !== 1'b0) begin
            fails++;
            $display("FAIL rx_data: DATA=%h PAR=%b, want 3c 0", DATA_RX, PARITY_RX);
        end
    endtask

    task automatic test_rx_glitch();
        int base = rdy_cnt;
        rx_drv = 1'b0;
        tick(4);
        rx_drv = 1'b1;
        tick(200);
        tests++;
        if (rdy_cnt != base || DATA_RX !== 8'h3C) begin
            fails++;
            $display("FAIL rx_glitch: pulses=%0d DATA=%h, want 0 3c", rdy_cnt - base, DATA_RX);
        end
    endtask

    task automatic test_rx_framing_err();
        logic [10:0] v = {1'b0, 1'b0, 8'h55, 1'b0};
        int base = rdy_cnt;
        for (int i = 0; i < 11; i++) begin
            rx_drv = v[i];
            tick(16);
        end
        rx_drv = 1'b1;
        tick(40);
        tests++;
        if (rdy_cnt != base || DATA_RX !== 8'h3C || PARITY_RX !== 1'b0) begin
            fails++;
            $display("FAIL rx_framing: pulses=%0d DATA=%h PAR=%b, want 0 3c 0",
                     rdy_cnt - base, DATA_RX, PARITY_RX);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] vals [3] = '{8'h00, 8'hFF, 8'h81};
        int base = rdy_cnt;
        int n;
        WORK_FR = 12'd8; loop = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            for (n = 0; n < 200 && READY_TX !== 1'b1; n++) tick(1);
            tests++;
            if (READY_TX !== 1'b1) begin
                fails++;
                $display("FAIL loop_wait_%0d: RDY_TX=%b, want 1", i, READY_TX);
            end
            DATA_TX = vals[i];
            START = 1'b1;
            tick(1);
        end
        for (n = 0; n < 200 && READY_TX !== 1'b1; n++) tick(1);
        START = 1'b0;
        tick(30);
        loop = 1'b0;
        tests++;
        if (rdy_cnt - base != 3) begin
            fails++;
            $display("FAIL loop_count: %0d pulses, want 3", rdy_cnt - base);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (base + i >= 8 || cap_d[base+i] !== vals[i] || cap_p[base+i] !== 1'b0) begin
                fails++;
                $display("FAIL loop_byte_%0d: got %h/%b, want %h/0",
                         i, cap_d[(base+i)%8], cap_p[(base+i)%8], vals[i]);
            end
        end
    endtask

    task automatic test_busy_start();
        logic [10:0] exp = {1'b1, 1'b0, 8'h0F, 1'b0};
        int bad = 0;
        WORK_FR = 12'd16; DATA_TX = 8'h0F; START = 1'b1;
        tick(1);
        START = 1'b0;
        for (int k = 0; k < 176; k++) begin
            if (k == 50) begin START = 1'b1; DATA_TX = 8'hFF; end
            if (k == 51) START = 1'b0;
            if (TX !== exp[k/16] || READY_TX !== 1'b0) begin
                if (bad == 0)
                    $display("FAIL busy_frame cycle %0d: TX=%b RDY_TX=%b, want %b 0",
                             k, TX, READY_TX, exp[k/16]);
                bad++;
            end
            tick(1);
        end
        tests++;
        if (bad != 0) fails++;
        tick(1);
        tests++;
        if (TX !== 1'b1 || READY_TX !== 1'b1) begin
            fails++;
            $display("FAIL busy_no_queue: TX=%b RDY_TX=%b, want 1 1", TX, READY_TX);
        end
    endtask

    task automatic test_reset_midframe();
        WORK_FR = 12'd16; DATA_TX = 8'h00; START = 1'b1;
        tick(1);
        START = 1'b0;
        tick(40);
        tests++;
        if (TX !== 1'b0 || READY_TX !== 1'b0) begin
            fails++;
            $display("FAIL pre_reset_busy: TX=%b RDY_TX=%b, want 0 0", TX, READY_TX);
        end
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        tests++;
        if (TX !== 1'b1 || READY_TX !== 1'b1 || DATA_RX !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid: TX=%b RDY_TX=%b DATA=%h, want 1 1 00", TX, READY_TX, DATA_RX);
        end
        tick(20);
        tests++;
        if (TX !== 1'b1 || READY_TX !== 1'b1) begin
            fails++;
            $display("FAIL reset_stays_idle: TX=%b RDY_TX=%b, want 1 1", TX, READY_TX);
        end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_min_period();
        test_rx_frame();
        test_rx_glitch();
        test_rx_framing_err();
        test_loopback();
        test_busy_start();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
